// File: rtl/dec_pkg.sv
// Shared types and helpers for the 4-to-16 sequenced decoder.
package dec_pkg;

  localparam int CODE_W   = 4;
  localparam int ONEHOT_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } dec_state_e;

  function automatic logic [ONEHOT_W-1:0] onehot16(input logic [CODE_W-1:0] code);
    onehot16 = {{(ONEHOT_W-1){1'b0}}, 1'b1} << code;
  endfunction

endpackage

// File: rtl/dec_hold_timer.sv
// Loadable down-counter; done pulses for one cycle when a loaded count expires.
module dec_hold_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             active_q, active_d;

  assign done = active_q && (cnt_q == {CNT_W{1'b0}});

  // next count and armed flag; a load on the done cycle re-arms without a gap
  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = load_val;
      active_d = 1'b1;
    end else if (done) begin
      active_d = 1'b0;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // counter state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= {CNT_W{1'b0}};
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/decoder_4x16_seq.sv
// Handshaked 4-to-16 one-hot decoder with hold time, break-before-make gap and one pending slot.
// Optional DEC_STATS_EN adds a saturating drive counter (dec_count) and a stall pulse (overrun).
module decoder_4x16_seq
  import dec_pkg::*;
#(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1,
  parameter int CNT_W       = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in,
  output logic [ONEHOT_W-1:0] out,
  output logic                out_valid,
`ifdef DEC_STATS_EN
  output logic [15:0]         dec_count,
  output logic                overrun,
`endif
  output logic                busy
);

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  dec_state_e          state_q, state_d;
  logic [CODE_W-1:0]   code_q, code_d;
  logic [CODE_W-1:0]   pend_q, pend_d;
  logic                pend_full_q, pend_full_d;
  logic [ONEHOT_W-1:0] out_q, out_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;
  logic                in_ready_q, in_ready_d;

  logic              xfer_s, nxt_avail_s, consume_s, tmr_load_s, tmr_done_s;
  logic [CODE_W-1:0] nxt_code_s;
  logic [CNT_W-1:0]  tmr_val_s;

  assign xfer_s = in_valid && in_ready_q;
  // a code offered on the expiring cycle is taken straight to DRIVE when the slot is empty
  assign nxt_avail_s = pend_full_q || (xfer_s && (state_q != IDLE));
  assign nxt_code_s  = pend_full_q ? pend_q : in;

  dec_hold_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .done     (tmr_done_s)
  );

  // next state, active code, pending slot and timer loads
  always_comb begin
    state_d     = state_q;
    code_d      = code_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    consume_s   = 1'b0;
    tmr_load_s  = 1'b0;
    tmr_val_s   = HOLD_LD;
    case (state_q)
      IDLE: begin
        if (xfer_s) begin
          state_d    = DRIVE;
          code_d     = in;
          tmr_load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DRIVE: begin
        if (!tmr_done_s) begin
          state_d = DRIVE;
        end else if (GAP_CYCLES > 0) begin
          state_d    = GAP;
          tmr_load_s = 1'b1;
          tmr_val_s  = GAP_LD;
        end else if (nxt_avail_s) begin
          state_d    = DRIVE;
          code_d     = nxt_code_s;
          consume_s  = 1'b1;
          tmr_load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      GAP: begin
        if (!tmr_done_s) begin
          state_d = GAP;
        end else if (nxt_avail_s) begin
          state_d    = DRIVE;
          code_d     = nxt_code_s;
          consume_s  = 1'b1;
          tmr_load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (consume_s) begin
      pend_full_d = 1'b0;
    end else begin
      pend_full_d = pend_full_q;
    end
    if (xfer_s && (state_q != IDLE) && !(consume_s && !pend_full_q)) begin
      pend_d      = in;
      pend_full_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

  // registered outputs derived from the next state
  always_comb begin
    if (state_d == DRIVE) begin
      out_d       = onehot16(code_d);
      out_valid_d = 1'b1;
    end else begin
      out_d       = {ONEHOT_W{1'b0}};
      out_valid_d = 1'b0;
    end
    busy_d     = (state_d != IDLE) || pend_full_d;
    in_ready_d = (state_d == IDLE) || !pend_full_d;
  end

  // control and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      code_q      <= {CODE_W{1'b0}};
      pend_q      <= {CODE_W{1'b0}};
      pend_full_q <= 1'b0;
      out_q       <= {ONEHOT_W{1'b0}};
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      code_q      <= code_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign in_ready  = in_ready_q;

`ifdef DEC_STATS_EN
  logic [15:0] stat_cnt_q, stat_cnt_d;
  logic        drive_entry_s;

  assign drive_entry_s = (state_d == DRIVE) && ((state_q != DRIVE) || tmr_done_s);

  // saturating count of DRIVE entries
  always_comb begin
    if (drive_entry_s && (stat_cnt_q != 16'hFFFF)) begin
      stat_cnt_d = stat_cnt_q + 16'd1;
    end else begin
      stat_cnt_d = stat_cnt_q;
    end
  end

  // statistics register
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_cnt_q <= 16'd0;
    end else begin
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign dec_count = stat_cnt_q;
  assign overrun   = in_valid && !in_ready_q && pend_full_q;
`endif

endmodule
